// File: rtl/accel_tilt_motion_pkg.sv
// Shared types and constants for the tilt-to-motion controller.
package accel_tilt_motion_pkg;

    localparam int ACCEL_W      = 9;
    localparam int ACCEL_CENTER = 256;
    localparam int CNT_W        = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POS  = 2'd1,
        ST_NEG  = 2'd2
    } axis_state_t;

endpackage

// File: rtl/accel_tilt_motion_if.sv
// Accelerometer inputs, step pulses and debug tilt values between the game logic and this block.
interface accel_tilt_motion_if;
    import accel_tilt_motion_pkg::*;

    logic                      enable;
    logic [ACCEL_W-1:0]        accel_x;
    logic [ACCEL_W-1:0]        accel_y;
    logic                      x_increment;
    logic                      x_decrement;
    logic                      y_increment;
    logic                      y_decrement;
    logic signed [ACCEL_W-1:0] tilt_x;
    logic signed [ACCEL_W-1:0] tilt_y;

    modport master (
        output enable, accel_x, accel_y,
        input  x_increment, x_decrement, y_increment, y_decrement, tilt_x, tilt_y
    );

    modport slave (
        input  enable, accel_x, accel_y,
        output x_increment, x_decrement, y_increment, y_decrement, tilt_x, tilt_y
    );

endinterface

// File: rtl/accel_tilt_motion_tilt_axis.sv
// One accelerometer axis: 4-sample moving average, dead-zone FSM and step-period timer.
//   state   | meaning
//   ST_IDLE | inside dead zone, no stepping
//   ST_POS  | tilted positive, stepping in + direction
//   ST_NEG  | tilted negative, stepping in - direction
module tilt_axis
    import accel_tilt_motion_pkg::*;
#(
    parameter int DEADZONE   = 16,
    parameter int HYST       = 8,
    parameter int PERIOD_MAX = 40,
    parameter int PERIOD_MIN = 4,
    parameter int SHIFT      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      hold,
    input  logic [ACCEL_W-1:0]        accel,
    output logic                      step_pos,
    output logic                      step_neg,
    output logic signed [ACCEL_W-1:0] tilt
);

    localparam logic [ACCEL_W-1:0] CENTER = ACCEL_W'(ACCEL_CENTER);
    localparam logic [ACCEL_W-1:0] DZ     = ACCEL_W'(DEADZONE);
    localparam logic [ACCEL_W-1:0] STOP   = ACCEL_W'(DEADZONE - HYST);
    localparam logic [ACCEL_W-1:0] SPAN   = ACCEL_W'(PERIOD_MAX - PERIOD_MIN);
    localparam logic [ACCEL_W-1:0] PMAX_W = ACCEL_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0]   PMAX   = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0]   PMIN   = CNT_W'(PERIOD_MIN);

    // Three stored samples plus the sample taken this tick form the 4-entry window.
    logic [ACCEL_W-1:0]        hist [3];
    logic [ACCEL_W+1:0]        sum;
    logic [ACCEL_W-1:0]        avg;
    logic signed [ACCEL_W-1:0] dev;
    logic [ACCEL_W-1:0]        abs_dev;
    logic [ACCEL_W-1:0]        excess;
    logic [ACCEL_W-1:0]        reduce;
    logic [CNT_W-1:0]          period;
    logic                      enter_pos, enter_neg, stop_pos, stop_neg;

    axis_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pos_n, neg_n;

    always_comb begin
        sum     = {2'b00, accel} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
        avg     = ACCEL_W'(sum >> 2);
        dev     = signed'(avg - CENTER);
        abs_dev = dev[ACCEL_W-1] ? (CENTER - avg) : (avg - CENTER);
        excess  = abs_dev - DZ;
        reduce  = excess >> SHIFT;
        // Compare before subtracting so the period never wraps below PERIOD_MIN.
        if (abs_dev <= DZ) begin
            period = PMAX;
        end else if (reduce >= SPAN) begin
            period = PMIN;
        end else begin
            period = CNT_W'(PMAX_W - reduce);
        end
        enter_pos = !dev[ACCEL_W-1] && (abs_dev > DZ);
        enter_neg =  dev[ACCEL_W-1] && (abs_dev > DZ);
        stop_pos  =  dev[ACCEL_W-1] || (abs_dev <= STOP);
        stop_neg  = !dev[ACCEL_W-1] || (abs_dev <= STOP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist[0] <= CENTER;
            hist[1] <= CENTER;
            hist[2] <= CENTER;
            tilt    <= '0;
        end else if (tick) begin
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            hist[0] <= accel;
            tilt    <= dev;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            step_pos <= 1'b0;
            step_neg <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            step_pos <= pos_n;
            step_neg <= neg_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pos_n   = 1'b0;
        neg_n   = 1'b0;
        if (hold) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (enter_pos) begin
                        state_n = ST_POS;
                        cnt_n   = period;
                        pos_n   = 1'b1;
                    end else if (enter_neg) begin
                        state_n = ST_NEG;
                        cnt_n   = period;
                        neg_n   = 1'b1;
                    end
                end
                ST_POS: begin
                    if (enter_neg) begin
                        state_n = ST_NEG;
                        cnt_n   = period;
                        neg_n   = 1'b1;
                    end else if (stop_pos) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (cnt <= CNT_W'(1)) begin
                        cnt_n = period;
                        pos_n = 1'b1;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                ST_NEG: begin
                    if (enter_pos) begin
                        state_n = ST_POS;
                        cnt_n   = period;
                        pos_n   = 1'b1;
                    end else if (stop_neg) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (cnt <= CNT_W'(1)) begin
                        cnt_n = period;
                        neg_n = 1'b1;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/accel_tilt_motion.sv
// Converts accelerometer tilt into ball step pulses: sample divider, enable gating, two axis engines.
module accel_tilt_motion
    import accel_tilt_motion_pkg::*;
#(
    parameter int SAMPLE_DIV = 100000,
    parameter int DEADZONE   = 16,
    parameter int HYST       = 8,
    parameter int PERIOD_MAX = 40,
    parameter int PERIOD_MIN = 4,
    parameter int SHIFT      = 2
) (
    input logic                clk,
    input logic                reset,
    accel_tilt_motion_if.slave bus
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             tick;
    logic             hold;

    assign tick = (div == DIV_W'(SAMPLE_DIV - 1));
    // Holding off motion only parks the FSMs; the filters keep tracking the sensor.
    assign hold = !bus.enable;

    always_ff @(posedge clk) begin
        if (!reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    tilt_axis #(
        .DEADZONE   (DEADZONE),
        .HYST       (HYST),
        .PERIOD_MAX (PERIOD_MAX),
        .PERIOD_MIN (PERIOD_MIN),
        .SHIFT      (SHIFT)
    ) u_axis_x (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .hold     (hold),
        .accel    (bus.accel_x),
        .step_pos (bus.x_increment),
        .step_neg (bus.x_decrement),
        .tilt     (bus.tilt_x)
    );

    tilt_axis #(
        .DEADZONE   (DEADZONE),
        .HYST       (HYST),
        .PERIOD_MAX (PERIOD_MAX),
        .PERIOD_MIN (PERIOD_MIN),
        .SHIFT      (SHIFT)
    ) u_axis_y (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .hold     (hold),
        .accel    (bus.accel_y),
        .step_pos (bus.y_increment),
        .step_neg (bus.y_decrement),
        .tilt     (bus.tilt_y)
    );

endmodule
